tcdm_rr_arbiter: RTL and testbench

Shares one TCDM master port between NR requesters, for example multiple streamers or engines in front of a single tcdm_model port or bank. Uses round-robin request arbitration. Routes in-order responses back to the issuing requester through a small ID FIFO. Flags any response that arrives with nothing outstanding.

---
 rtl/tcdm_rr_arbiter.sv | 110 +++++++++++
 tb/tb_tcdm_rr_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_rr_arbiter.sv
// tcdm_rr_arbiter: round-robin sharing of one TCDM port with in-order response routing.
// Define TCDM_ARB_PERF_CNT_EN to add per-requester grant/stall counters.
module tcdm_rr_arbiter #(
    parameter int NR = 4,
    parameter int RESP_DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
`ifdef TCDM_ARB_PERF_CNT_EN
    input  logic               perf_clr_i,
    output logic [NR*32-1:0]   perf_gnt_cnt_o,
    output logic [NR*32-1:0]   perf_stall_cnt_o,
`endif
    input  logic [NR-1:0]      in_req_i,
    output logic [NR-1:0]      in_gnt_o,
    input  logic [NR*32-1:0]   in_add_i,
    input  logic [NR-1:0]      in_wen_i,
    input  logic [NR*4-1:0]    in_be_i,
    input  logic [NR*32-1:0]   in_data_i,
    output logic [NR*32-1:0]   in_r_data_o,
    output logic [NR-1:0]      in_r_valid_o,
    output logic               out_req_o,
    input  logic               out_gnt_i,
    output logic [31:0]        out_add_o,
    output logic               out_wen_o,
    output logic [3:0]         out_be_o,
    output logic [31:0]        out_data_o,
    input  logic [31:0]        out_r_data_i,
    input  logic               out_r_valid_i,
    output logic               err_o
);
    localparam int IDW = $clog2(NR);
    localparam int PW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam logic [IDW:0] NR_W = (IDW + 1)'(NR);
    localparam logic [IDW-1:0] LAST = IDW'(NR - 1);
    localparam logic [PW-1:0] PLAST = PW'(RESP_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(RESP_DEPTH);

    logic [IDW-1:0] rr_q, win, head;
    logic [IDW-1:0] ids_q [RESP_DEPTH];
    logic [PW-1:0]  wr_q, rd_q;
    logic [CW-1:0]  cnt_q;
    logic [IDW:0]   sum;
    logic           full, empty, hs, pop;

    // Scan downward so the last hit is the first requester at or after rr_q.
    always_comb begin
        win = rr_q;
        sum = '0;
        for (int i = NR - 1; i >= 0; i--) begin
            sum = {1'b0, rr_q} + (IDW + 1)'(i);
            sum = sum >= NR_W ? sum - NR_W : sum;
            win = in_req_i[sum[IDW-1:0]] ? sum[IDW-1:0] : win;
        end
    end

    assign full = cnt_q == FULL;
    assign empty = cnt_q == '0;
    assign out_req_o = |in_req_i & ~full;
    assign hs = out_req_o & out_gnt_i;
    assign pop = out_r_valid_i & ~empty;
    assign head = ids_q[rd_q];

    assign out_add_o = out_req_o ? in_add_i[win*32 +: 32] : '0;
    assign out_wen_o = out_req_o ? in_wen_i[win] : 1'b0;
    assign out_be_o = out_req_o ? in_be_i[win*4 +: 4] : '0;
    assign out_data_o = out_req_o ? in_data_i[win*32 +: 32] : '0;
    assign in_gnt_o = hs ? (NR'(1) << win) : '0;
    assign in_r_valid_o = pop ? (NR'(1) << head) : '0;
    assign in_r_data_o = {NR{out_r_data_i}};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            err_o <= 1'b0;
        end else begin
            if (hs) begin
                ids_q[wr_q] <= win;
                wr_q <= wr_q == PLAST ? '0 : wr_q + 1'b1;
                rr_q <= win == LAST ? '0 : win + 1'b1;
            end
            if (pop) rd_q <= rd_q == PLAST ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(hs) - CW'(pop);
            if (out_r_valid_i & empty) err_o <= 1'b1;
        end
    end

`ifdef TCDM_ARB_PERF_CNT_EN
    logic [31:0] gnt_cnt [NR];
    logic [31:0] stall_cnt [NR];

    for (genvar g = 0; g < NR; g++) begin : g_perf
        always_ff @(posedge clk_i) begin
            if (rst_i || perf_clr_i) begin
                gnt_cnt[g] <= '0;
                stall_cnt[g] <= '0;
            end else begin
                if (in_gnt_o[g] && gnt_cnt[g] != '1) gnt_cnt[g] <= gnt_cnt[g] + 1'b1;
                if (in_req_i[g] && !in_gnt_o[g] && stall_cnt[g] != '1) stall_cnt[g] <= stall_cnt[g] + 1'b1;
            end
        end
        assign perf_gnt_cnt_o[g*32 +: 32] = gnt_cnt[g];
        assign perf_stall_cnt_o[g*32 +: 32] = stall_cnt[g];
    end
`endif
endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// tb_tcdm_rr_arbiter: directed and random checks of tcdm_rr_arbiter against a queue-based model.
module tb_tcdm_rr_arbiter;
    localparam int NR = 4;
    localparam int RD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    req = '0, in_gnt, wen = '0, in_r_valid;
    logic [NR*32-1:0] add = '0, data = '0, in_r_data;
    logic [NR*4-1:0]  be = '0;
    logic             out_req, gnt = 1'b0, out_wen, rvalid = 1'b0, err;
    logic [31:0]      out_add, out_data, rdata = '0;
    logic [3:0]       out_be;
`ifdef TCDM_ARB_PERF_CNT_EN
    logic [NR*32-1:0] perf_gnt, perf_stall;
`endif

    tcdm_rr_arbiter #(.NR(NR), .RESP_DEPTH(RD)) dut (
        .clk_i(clk), .rst_i(rst),
`ifdef TCDM_ARB_PERF_CNT_EN
        .perf_clr_i(1'b0), .perf_gnt_cnt_o(perf_gnt), .perf_stall_cnt_o(perf_stall),
`endif
        .in_req_i(req), .in_gnt_o(in_gnt), .in_add_i(add), .in_wen_i(wen),
        .in_be_i(be), .in_data_i(data), .in_r_data_o(in_r_data), .in_r_valid_o(in_r_valid),
        .out_req_o(out_req), .out_gnt_i(gnt), .out_add_o(out_add), .out_wen_o(out_wen),
        .out_be_o(out_be), .out_data_o(out_data), .out_r_data_i(rdata),
        .out_r_valid_i(rvalid), .err_o(err)
    );

    typedef struct { int id; logic [31:0] d; } rsp_t;
    rsp_t        oq[$];
    int          gl[$];
    int          ptr = 0;
    bit          errm = 0;
    bit          pend [NR];
    logic [31:0] mem [int];
    logic [31:0] lastr [NR];
    logic [NR-1:0] seenv = '0;
    int          npass = 0, ntot = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] init_w(input int a);
        return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rdm(input int a);
        return mem.exists(a) ? mem[a] : init_w(a);
    endfunction

    // One cycle: check combinational outputs against the model, then advance it at the edge.
    task automatic step();
        int w, ws;
        bit oreq, hs, pop;
        logic [NR-1:0] eg, ev;
        logic [31:0] a, old, nw;
        rdata = oq.size() > 0 ? oq[0].d : 32'($urandom);
        #1;
        w = -1;
        for (int i = 0; i < NR; i++) if (w < 0 && req[(ptr + i) % NR]) w = (ptr + i) % NR;
        ws = w < 0 ? 0 : w;
        oreq = w >= 0 && oq.size() < RD;
        hs = oreq && gnt;
        pop = rvalid && oq.size() > 0;
        eg = hs ? (NR'(1) << ws) : '0;
        ev = pop ? (NR'(1) << oq[0].id) : '0;
        chk("out_req", 64'(out_req), 64'(oreq));
        chk("in_gnt", 64'(in_gnt), 64'(eg));
        chk("out_add", 64'(out_add), 64'(oreq ? add[ws*32 +: 32] : 32'h0));
        chk("out_wen", 64'(out_wen), 64'(oreq ? wen[ws] : 1'b0));
        chk("out_be", 64'(out_be), 64'(oreq ? be[ws*4 +: 4] : 4'h0));
        chk("out_data", 64'(out_data), 64'(oreq ? data[ws*32 +: 32] : 32'h0));
        chk("r_valid", 64'(in_r_valid), 64'(ev));
        if (pop) chk("r_data", 64'(in_r_data[oq[0].id*32 +: 32]), 64'(oq[0].d));
        chk("err", 64'(err), 64'(errm));
        for (int k = 0; k < NR; k++) if (in_r_valid[k]) begin
            lastr[k] = in_r_data[k*32 +: 32];
            seenv[k] = 1'b1;
        end
        @(posedge clk);
        if (rst) begin
            ptr = 0;
            oq.delete();
            errm = 0;
            pend = '{default: 1'b0};
        end else begin
            if (pop) void'(oq.pop_front());
            else if (rvalid) errm = 1;
            if (hs) begin
                a = add[ws*32 +: 32];
                old = rdm(int'(a));
                if (wen[ws]) oq.push_back('{ws, old});
                else begin
                    for (int b = 0; b < 4; b++) nw[8*b +: 8] = be[ws*4 + b] ? data[ws*32 + 8*b +: 8] : old[8*b +: 8];
                    mem[int'(a)] = nw;
                    oq.push_back('{ws, 32'h0});
                end
                ptr = (ws + 1) % NR;
                pend[ws] = 1'b0;
                gl.push_back(ws);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        req = '0;
        gnt = 1'b0;
        for (int i = 0; i < 8 && oq.size() > 0; i++) begin
            rvalid = 1'b1;
            step();
        end
        rvalid = 1'b0;
    endtask

    task automatic rand_req();
        for (int k = 0; k < NR; k++) begin
            if (!pend[k] && $urandom_range(0, 2) == 0) begin
                pend[k] = 1'b1;
                add[k*32 +: 32] = 32'($urandom_range(0, 15)) << 2;
                wen[k] = 1'($urandom);
                be[k*4 +: 4] = 4'($urandom);
                data[k*32 +: 32] = 32'($urandom);
            end
            req[k] = pend[k];
        end
    endtask

    initial begin
        logic [31:0] iv;
        pend = '{default: 1'b0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        repeat (10) step();
        chk("idle_no_grant", 64'(gl.size()), 64'd0);

        for (int k = 0; k < NR; k++) add[k*32 +: 32] = 32'h100 + 32'(k * 4);
        wen = '1;
        be = '1;
        req = '1;
        gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rvalid = oq.size() > 0;
            step();
        end
        chk("rr_count", 64'(gl.size()), 64'd6);
        for (int i = 0; i < 6 && i < gl.size(); i++) chk("rr_order", 64'(gl[i]), 64'(i % NR));
        drain();

        gl.delete();
        req = 4'b0100;
        add[2*32 +: 32] = 32'h40;
        repeat (3) step();
        chk("stall_no_grant", 64'(gl.size()), 64'd0);
        gnt = 1'b1;
        step();
        chk("stall_one_grant", 64'(gl.size()), 64'd1);
        drain();
        req = '1;
        #1;
        chk("ptr_after_stall", 64'(out_add), 64'(add[3*32 +: 32]));

        gl.delete();
        gnt = 1'b1;
        repeat (4) step();
        chk("full_two_grants", 64'(gl.size()), 64'd2);
        chk("full_req_low", 64'(out_req), 64'd0);
        rvalid = 1'b1;
        step();
        chk("full_no_bypass", 64'(gl.size()), 64'd2);
        rvalid = 1'b0;
        step();
        chk("full_one_more", 64'(gl.size()), 64'd3);
        step();
        chk("full_again", 64'(gl.size()), 64'd3);
        drain();

        seenv = '0;
        add[1*32 +: 32] = 32'h10;
        wen[1] = 1'b0;
        be[1*4 +: 4] = 4'b0011;
        data[1*32 +: 32] = 32'hAABBCCDD;
        req = 4'b0010;
        gnt = 1'b1;
        step();
        add[3*32 +: 32] = 32'h10;
        wen[3] = 1'b1;
        req = 4'b1000;
        rvalid = 1'b1;
        step();
        chk("write_rvalid", 64'(seenv[1]), 64'd1);
        req = '0;
        step();
        iv = init_w(16);
        chk("read_merged", 64'(lastr[3]), 64'({iv[31:16], 16'hCCDD}));
        rvalid = 1'b0;
        drain();

        rvalid = 1'b1;
        step();
        rvalid = 1'b0;
        repeat (3) step();
        chk("err_sticky", 64'(err), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("err_cleared", 64'(err), 64'd0);

        for (int c = 0; c < 3000; c++) begin
            rand_req();
            gnt = $urandom_range(0, 3) != 0;
            rvalid = oq.size() > 0 ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 40) == 0);
            rst = $urandom_range(0, 400) == 0;
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
